// File: rtl/fft_bitrev_pingpong_buf.sv
// fft_bitrev_pingpong_buf
// Ping-pong buffer between cyclic-prefix removal and the FFT input. Each
// OFDM symbol of N = 2**LOG2N samples is written in natural order into one
// bank. Each full bank is then replayed in bit-reversed index order while
// the other bank fills. Symbol framing is checked against s_tlast.
//
// Handshake: a beat transfers on a rising ap_clk edge where valid & ready are
// both 1. A source holds data/last stable while valid & !ready. Valid never
// depends combinationally on ready, and here both ready and valid are
// registered.
module fft_bitrev_pingpong_buf #(
   parameter int DATA_W = 32,
   parameter int LOG2N  = 6
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic              s_tvalid,
   output logic              s_tready,
   input  logic              s_tlast,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast,
   output logic              sym_done,
   output logic              err_short,
   output logic              err_long
);

   localparam int N = 1 << LOG2N;

   typedef logic [LOG2N-1:0] idx_t;

   // Read-side state, kept in a named register so it can be probed directly.
   typedef enum logic [1:0] {
      RD_IDLE   = 2'd0,
      RD_PRIME  = 2'd1,
      RD_STREAM = 2'd2
   } rd_state_t;

   // Both banks share one array; the bank select is the address MSB.
   logic [DATA_W-1:0] mem [0:2*N-1];

   idx_t        wr_idx;
   idx_t        rd_idx;
   logic        wr_sel;
   logic        rd_sel;
   logic [1:0]  full;
   logic [1:0]  full_next;
   rd_state_t   rd_state;

   logic        wr_fire;
   logic        wr_last_idx;
   logic        commit;
   logic        short_sym;
   logic        rd_release;
   logic        wr_sel_next;
   idx_t        rd_fetch_idx;
   logic [LOG2N:0] wr_addr;
   logic [LOG2N:0] rd_addr;

   // Reverse the LOG2N index bits (N=64: 1->32, 2->16, 3->48).
   function automatic idx_t bitrev(input idx_t v);
      idx_t r;
      r = '0;
      for (int i = 0; i < LOG2N; i++) begin
         r[i] = v[LOG2N-1-i];
      end
      return r;
   endfunction

   // Shared next-state terms for the write side, bank flags and read address.
   always_comb begin
      wr_fire     = s_tvalid & s_tready;
      wr_last_idx = (wr_idx == idx_t'(N-1));
      commit      = wr_fire & wr_last_idx;
      short_sym   = wr_fire & s_tlast & ~wr_last_idx;
      // m_tvalid is always 1 in STREAM, so this is the m_tlast handshake.
      rd_release  = (rd_state == RD_STREAM) & m_tvalid & m_tready & m_tlast;

      // The writer only fills a non-full bank and the reader only releases
      // a full one, so a commit and a release never touch the same bank.
      full_next = full;
      if (commit) begin
         full_next[wr_sel] = 1'b1;
      end
      if (rd_release) begin
         full_next[rd_sel] = 1'b0;
      end

      wr_sel_next = wr_sel ^ commit;

      // PRIME fetches index 0; STREAM prefetches the index after the one shown.
      if (rd_state == RD_STREAM) begin
         rd_fetch_idx = rd_idx + idx_t'(1);
      end else begin
         rd_fetch_idx = '0;
      end

      wr_addr = {wr_sel, wr_idx};
      rd_addr = {rd_sel, bitrev(rd_fetch_idx)};
   end

   // Write side: index counter, bank select, full flags, ready and framing errors.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         wr_idx    <= '0;
         wr_sel    <= 1'b0;
         full      <= 2'b00;
         s_tready  <= 1'b0;
         err_short <= 1'b0;
         err_long  <= 1'b0;
      end else begin
         full      <= full_next;
         wr_sel    <= wr_sel_next;
         // Ready looks at next-cycle flags, so a bank released on this edge
         // is writable from the following edge onward.
         s_tready  <= ~full_next[wr_sel_next];
         err_short <= short_sym;
         err_long  <= commit & ~s_tlast;
         if (commit || short_sym) begin
            // A short symbol restarts the same bank; its partial data is dropped.
            wr_idx <= '0;
         end else if (wr_fire) begin
            wr_idx <= wr_idx + idx_t'(1);
         end
      end
   end

   // Sample storage; no reset, a bank is only read after the full flag is set.
   always_ff @(posedge ap_clk) begin
      if (wr_fire) begin
         mem[wr_addr] <= s_tdata;
      end
   end

   // Read FSM: wait for a full bank, prime the first read, then stream in
   // bit-reversed order, advancing only on an accepted beat.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         rd_state <= RD_IDLE;
         rd_sel   <= 1'b0;
         rd_idx   <= '0;
         m_tdata  <= '0;
         m_tvalid <= 1'b0;
         m_tlast  <= 1'b0;
         sym_done <= 1'b0;
      end else begin
         sym_done <= rd_release;
         case (rd_state)
            RD_IDLE: begin
               if (full[rd_sel]) begin
                  rd_state <= RD_PRIME;
               end
            end
            RD_PRIME: begin
               m_tdata  <= mem[rd_addr];
               rd_idx   <= '0;
               m_tvalid <= 1'b1;
               m_tlast  <= (LOG2N == 0);
               rd_state <= RD_STREAM;
            end
            RD_STREAM: begin
               if (m_tready) begin
                  if (m_tlast) begin
                     m_tvalid <= 1'b0;
                     m_tlast  <= 1'b0;
                     rd_idx   <= '0;
                     rd_sel   <= ~rd_sel;
                     // Includes a commit into the other bank on this same edge.
                     if (full_next[~rd_sel]) begin
                        rd_state <= RD_PRIME;
                     end else begin
                        rd_state <= RD_IDLE;
                     end
                  end else begin
                     m_tdata <= mem[rd_addr];
                     rd_idx  <= rd_fetch_idx;
                     m_tlast <= (rd_fetch_idx == idx_t'(N-1));
                  end
               end
            end
            default: begin
               rd_state <= RD_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fft_bitrev_pingpong_buf.sv
// Testbench for fft_bitrev_pingpong_buf (N = 64): directed steps with a
// bit-reversed-order scoreboard and immediate assertions.
module tb_fft_bitrev_pingpong_buf;

   localparam int DATA_W = 32;
   localparam int LOG2N  = 6;
   localparam int N      = 64;
   localparam int W      = DATA_W + 1;

   // ---------------- clock / reset ----------------
   logic ap_clk   = 1'b0;
   logic ap_rst_n = 1'b0;
   always #5 ap_clk = ~ap_clk;

   logic [DATA_W-1:0] s_tdata;
   logic              s_tvalid;
   logic              s_tready;
   logic              s_tlast;
   logic [DATA_W-1:0] m_tdata;
   logic              m_tvalid;
   logic              m_tready;
   logic              m_tlast;
   logic              sym_done;
   logic              err_short;
   logic              err_long;

   fft_bitrev_pingpong_buf #(.DATA_W(DATA_W), .LOG2N(LOG2N)) dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .s_tdata   (s_tdata),
      .s_tvalid  (s_tvalid),
      .s_tready  (s_tready),
      .s_tlast   (s_tlast),
      .m_tdata   (m_tdata),
      .m_tvalid  (m_tvalid),
      .m_tready  (m_tready),
      .m_tlast   (m_tlast),
      .sym_done  (sym_done),
      .err_short (err_short),
      .err_long  (err_long)
   );

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];   // {tlast, data}
   int pass_cnt  = 0;
   int total_cnt = 0;
   int out_cnt   = 0;
   int short_cnt = 0;
   int long_cnt  = 0;
   int done_cnt  = 0;
   int stall_run = 0;
   int max_stall = 0;
   logic         hold_v = 1'b0;
   logic [W-1:0] hold_beat;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [LOG2N-1:0] brev(input logic [LOG2N-1:0] v);
      return {<<{v}};
   endfunction

   // Output monitor: sampled on the falling edge, between active edges.
   always @(negedge ap_clk) begin
      if (!ap_rst_n) begin
         hold_v    = 1'b0;
         stall_run = 0;
      end else begin
         if (err_short) short_cnt++;
         if (err_long)  long_cnt++;
         if (sym_done)  done_cnt++;
         if (s_tvalid && !s_tready) begin
            stall_run++;
            if (stall_run > max_stall) max_stall = stall_run;
         end else begin
            stall_run = 0;
         end
         if (hold_v) begin
            check("hold_valid", 64'(m_tvalid), 64'd1);
            check("hold_beat", 64'({m_tlast, m_tdata}), 64'(hold_beat));
         end
         hold_v = 1'b0;
         if (m_tvalid && m_tready) begin
            out_cnt++;
            check("out_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
               check("out_beat", 64'({m_tlast, m_tdata}), 64'(exp_q.pop_front()));
            end
         end else if (m_tvalid) begin
            hold_v    = 1'b1;
            hold_beat = {m_tlast, m_tdata};
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic put(input logic [DATA_W-1:0] d, input logic last);
      int w;
      s_tdata  = d;
      s_tvalid = 1'b1;
      s_tlast  = last;
      w = 0;
      @(negedge ap_clk);
      while (!s_tready && w < 1000) begin
         @(negedge ap_clk);
         w++;
      end
      if (w >= 1000) check("in_accept_timeout", 64'(s_tready), 64'd1);
      @(posedge ap_clk);
      #1;
   endtask

   // Sends n samples base+k; s_tlast on index last_at (-1 = never).
   task automatic send_sym(input logic [DATA_W-1:0] base, input int n, input int last_at,
                           input bit expect_out);
      if (expect_out) begin
         for (int k = 0; k < N; k++) begin
            exp_q.push_back({(k == N-1), base + DATA_W'(brev(LOG2N'(k)))});
         end
      end
      for (int k = 0; k < n; k++) begin
         put(base + DATA_W'(k), (k == last_at));
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < budget) begin
         @(negedge ap_clk);
         w++;
      end
      check("drain_q_empty", 64'(exp_q.size()), 64'd0);
      repeat (3) @(posedge ap_clk);
      #1;
   endtask

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int d_done;
      int d_short;
      int d_long;
      int w;

      s_tdata  = '0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      m_tready = 1'b1;
      ap_rst_n = 1'b0;

      // Reset values
      repeat (3) @(posedge ap_clk);
      #1;
      check("rst_s_tready",  64'(s_tready),  64'd0);
      check("rst_m_tvalid",  64'(m_tvalid),  64'd0);
      check("rst_m_tlast",   64'(m_tlast),   64'd0);
      check("rst_m_tdata",   64'(m_tdata),   64'd0);
      check("rst_sym_done",  64'(sym_done),  64'd0);
      check("rst_err_short", 64'(err_short), 64'd0);
      check("rst_err_long",  64'(err_long),  64'd0);
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      check("rel_ready_before_edge", 64'(s_tready), 64'd0);
      @(posedge ap_clk);
      #1;
      check("rel_ready_after_edge", 64'(s_tready), 64'd1);

      // 1: single symbol 0..63, latency and bit-reversed order
      d_done = done_cnt; d_short = short_cnt; d_long = long_cnt;
      send_sym(32'h0, N, N-1, 1'b1);
      @(negedge ap_clk);
      check("t1_lat_c0_valid", 64'(m_tvalid), 64'd0);
      @(negedge ap_clk);
      check("t1_lat_c1_valid", 64'(m_tvalid), 64'd0);
      @(negedge ap_clk);
      check("t1_lat_c2_valid", 64'(m_tvalid), 64'd1);
      check("t1_first_data", 64'(m_tdata), 64'd0);
      wait_drain(300);
      check("t1_sym_done", 64'(done_cnt - d_done), 64'd1);
      check("t1_no_err", 64'((short_cnt - d_short) + (long_cnt - d_long)), 64'd0);

      // 2: three back-to-back symbols, input stall bounded
      d_done = done_cnt; d_short = short_cnt; d_long = long_cnt;
      max_stall = 0;
      send_sym(32'h1000_0000, N, N-1, 1'b1);
      send_sym(32'h2000_0000, N, N-1, 1'b1);
      send_sym(32'h3000_0000, N, N-1, 1'b1);
      wait_drain(500);
      check("t2_max_stall_le2", 64'(max_stall <= 2), 64'd1);
      check("t2_sym_done", 64'(done_cnt - d_done), 64'd3);
      check("t2_no_err", 64'((short_cnt - d_short) + (long_cnt - d_long)), 64'd0);

      // 3: back-pressure; both banks full blocks input, toggling ready holds data
      d_done = done_cnt;
      m_tready = 1'b0;
      send_sym(32'h4000_0000, N, N-1, 1'b1);
      send_sym(32'h5000_0000, N, N-1, 1'b1);
      for (int i = 0; i < 20; i++) begin
         @(negedge ap_clk);
         check("t3_both_full_ready", 64'(s_tready), 64'd0);
      end
      check("t3_stalled_valid", 64'(m_tvalid), 64'd1);
      fork
         send_sym(32'h6000_0000, N, N-1, 1'b1);
         begin
            for (int i = 0; i < 300; i++) begin
               m_tready = (i % 2 == 0);
               @(posedge ap_clk);
               #1;
            end
            m_tready = 1'b1;
         end
      join
      wait_drain(500);
      check("t3_sym_done", 64'(done_cnt - d_done), 64'd3);

      // 4: short symbol (tlast at index 9) is dropped, next symbol intact
      d_done = done_cnt; d_short = short_cnt;
      send_sym(32'h7000_0000, 10, 9, 1'b0);
      @(negedge ap_clk);
      check("t4_err_short_pulse", 64'(err_short), 64'd1);
      @(negedge ap_clk);
      check("t4_err_short_low", 64'(err_short), 64'd0);
      repeat (10) @(negedge ap_clk);
      check("t4_no_output", 64'(m_tvalid), 64'd0);
      @(posedge ap_clk);
      #1;
      send_sym(32'h8000_0000, N, N-1, 1'b1);
      wait_drain(300);
      check("t4_short_count", 64'(short_cnt - d_short), 64'd1);
      check("t4_sym_done", 64'(done_cnt - d_done), 64'd1);

      // 5: 64 samples without tlast -> err_long, symbol still output
      d_done = done_cnt; d_long = long_cnt;
      send_sym(32'h9000_0000, N, -1, 1'b1);
      @(negedge ap_clk);
      check("t5_err_long_pulse", 64'(err_long), 64'd1);
      @(negedge ap_clk);
      check("t5_err_long_low", 64'(err_long), 64'd0);
      wait_drain(300);
      check("t5_long_count", 64'(long_cnt - d_long), 64'd1);
      check("t5_sym_done", 64'(done_cnt - d_done), 64'd1);

      // 6: reset at output beat 20, then a clean symbol
      out_cnt = 0;
      send_sym(32'hA000_0000, N, N-1, 1'b1);
      w = 0;
      while (out_cnt < 20 && w < 300) begin
         @(negedge ap_clk);
         w++;
      end
      check("t6_reached_beat20", 64'(out_cnt >= 20), 64'd1);
      #2;
      ap_rst_n = 1'b0;
      #1;
      check("t6_rst_m_tvalid", 64'(m_tvalid), 64'd0);
      check("t6_rst_m_tlast",  64'(m_tlast),  64'd0);
      check("t6_rst_m_tdata",  64'(m_tdata),  64'd0);
      check("t6_rst_s_tready", 64'(s_tready), 64'd0);
      exp_q.delete();
      repeat (3) @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b1;
      d_done = done_cnt;
      repeat (5) @(negedge ap_clk);
      check("t6_no_residue", 64'(m_tvalid), 64'd0);
      @(posedge ap_clk);
      #1;
      send_sym(32'hB000_0000, N, N-1, 1'b1);
      wait_drain(300);
      check("t6_sym_done", 64'(done_cnt - d_done), 64'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
